cf_sync_fifo: RTL and testbench

- Parametrised single-clock FIFO, the successor to the constant-function width checks.
- Every internal width is derived from parameters through a local constant function `clog2`. Nothing is hard-coded.
- Supports depths that are not a power of two, with explicit pointer wrap.
- Adds occupancy, almost-full and error reporting.
- Sits between producer and consumer blocks in the same clock domain.

---
 rtl/cf_sync_fifo.sv | 106 ++++++++++
 tb/tb_cf_sync_fifo.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cf_sync_fifo.sv
// cf_sync_fifo: single-clock FIFO with any DEPTH from 2 to 1024.
// Reports occupancy, almost-full and one-cycle overflow/underflow pulses.
package cf_sync_fifo_pkg;

    // Smallest w with 2**w >= n, never below 1.
    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

module cf_sync_fifo
    import cf_sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int DEPTH        = 6,
    parameter int AFULL_THRESH = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         wr_en,
    input  logic [DATA_WIDTH-1:0]        wr_data,
    input  logic                         rd_en,
    output logic [DATA_WIDTH-1:0]        rd_data,
    output logic                         rd_valid,
    output logic                         full,
    output logic                         almost_full,
    output logic                         empty,
    output logic [clog2(DEPTH+1)-1:0]    count,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int PTR_W = clog2(DEPTH);
    localparam int CNT_W = clog2(DEPTH + 1);

    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_AFULL = CNT_W'(AFULL_THRESH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             rd_ok;
    logic             wr_ok;
    logic [CNT_W-1:0] count_nxt;

    // Wrap is explicit so non-power-of-two depths never index past DEPTH-1.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        rd_ok     = rd_en && (count != '0);
        wr_ok     = wr_en && ((count != CNT_FULL) || rd_ok);
        count_nxt = count;
        if (wr_ok && !rd_ok) begin
            count_nxt = count + CNT_W'(1);
        end else if (rd_ok && !wr_ok) begin
            count_nxt = count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            rd_data     <= '0;
            rd_valid    <= 1'b0;
            full        <= 1'b0;
            almost_full <= 1'b0;
            empty       <= 1'b1;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (rd_ok) begin
                rd_ptr  <= ptr_inc(rd_ptr);
                rd_data <= mem[rd_ptr];
            end
            rd_valid    <= rd_ok;
            count       <= count_nxt;
            full        <= (count_nxt == CNT_FULL);
            almost_full <= (count_nxt >= CNT_AFULL);
            empty       <= (count_nxt == '0);
            overflow    <= wr_en && !wr_ok;
            underflow   <= rd_en && !rd_ok;
        end
    end

endmodule

// File: tb/tb_cf_sync_fifo.sv
// tb_cf_sync_fifo: directed and random checks of cf_sync_fifo against a queue model.
// Instance a uses DEPTH=6/AFULL=4, instance b uses DEPTH=8/AFULL=8.
module tb_cf_sync_fifo;

    typedef logic [7:0] byte_t;

    typedef struct {
        byte_t rd_data;
        bit    rd_valid;
        bit    full;
        bit    afull;
        bit    empty;
        int    count;
        bit    ov;
        bit    un;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    logic  wa = 1'b0, ra = 1'b0, wb = 1'b0, rb = 1'b0;
    byte_t da = '0, db = '0;

    byte_t      rd_data_a, rd_data_b;
    logic       rd_valid_a, full_a, afull_a, empty_a, ov_a, un_a;
    logic       rd_valid_b, full_b, afull_b, empty_b, ov_b, un_b;
    logic [2:0] count_a;
    logic [3:0] count_b;

    byte_t qa[$];
    byte_t qb[$];
    exp_t  ea, eb;
    int    checks = 0;
    int    failures = 0;

    wire [16:0] obs_a = {rd_data_a, rd_valid_a, full_a, afull_a,
                         empty_a, count_a, ov_a, un_a};
    wire [17:0] obs_b = {rd_data_b, rd_valid_b, full_b, afull_b,
                         empty_b, count_b, ov_b, un_b};

    cf_sync_fifo #(.DATA_WIDTH(8), .DEPTH(6), .AFULL_THRESH(4)) u_a (
        .clk(clk), .reset_n(reset_n),
        .wr_en(wa), .wr_data(da), .rd_en(ra),
        .rd_data(rd_data_a), .rd_valid(rd_valid_a),
        .full(full_a), .almost_full(afull_a), .empty(empty_a),
        .count(count_a), .overflow(ov_a), .underflow(un_a)
    );

    cf_sync_fifo #(.DATA_WIDTH(8), .DEPTH(8), .AFULL_THRESH(8)) u_b (
        .clk(clk), .reset_n(reset_n),
        .wr_en(wb), .wr_data(db), .rd_en(rb),
        .rd_data(rd_data_b), .rd_valid(rd_valid_b),
        .full(full_b), .almost_full(afull_b), .empty(empty_b),
        .count(count_b), .overflow(ov_b), .underflow(un_b)
    );

    initial forever #5 clk = ~clk;

    function automatic exp_t reset_exp();
        exp_t e;
        e.rd_data = '0;
        e.rd_valid = 0;
        e.full = 0;
        e.afull = 0;
        e.empty = 1;
        e.count = 0;
        e.ov = 0;
        e.un = 0;
        return e;
    endfunction

    function automatic logic [16:0] pack_a(input exp_t e);
        return {e.rd_data, e.rd_valid, e.full, e.afull,
                e.empty, 3'(e.count), e.ov, e.un};
    endfunction

    function automatic logic [17:0] pack_b(input exp_t e);
        return {e.rd_data, e.rd_valid, e.full, e.afull,
                e.empty, 4'(e.count), e.ov, e.un};
    endfunction

    // Behavioural FIFO: accept rules applied to a queue, pop before push.
    function automatic void mstep(input int which, input bit w,
                                  input byte_t d, input bit r);
        byte_t q[$];
        exp_t  e;
        int    depth, thr;
        bit    rok, wok;
        if (which == 0) begin
            q = qa; e = ea; depth = 6; thr = 4;
        end else begin
            q = qb; e = eb; depth = 8; thr = 8;
        end
        rok = r && (q.size() != 0);
        wok = w && ((q.size() != depth) || rok);
        e.rd_valid = rok;
        if (rok) e.rd_data = q.pop_front();
        if (wok) q.push_back(d);
        e.count = q.size();
        e.full  = (e.count == depth);
        e.afull = (e.count >= thr);
        e.empty = (e.count == 0);
        e.ov    = w && !wok;
        e.un    = r && !rok;
        if (which == 0) begin
            qa = q; ea = e;
        end else begin
            qb = q; eb = e;
        end
    endfunction

    task automatic step(input bit w_a, input byte_t d_a, input bit r_a,
                        input bit w_b = 0, input byte_t d_b = 0,
                        input bit r_b = 0);
        wa = w_a; da = d_a; ra = r_a;
        wb = w_b; db = d_b; rb = r_b;
        @(posedge clk);
        #1;
        mstep(0, w_a, d_a, r_a);
        mstep(1, w_b, d_b, r_b);
        wa = 0; ra = 0; wb = 0; rb = 0;
    endtask

    task automatic test_reset();
        reset_n = 0;
        repeat (2) @(posedge clk);
        #1;
        qa.delete(); qb.delete();
        ea = reset_exp(); eb = reset_exp();
        checks++;
        if (rd_data_a !== 8'h00) begin
            failures++;
            $display("FAIL reset_rd_data got=%h exp=00", rd_data_a);
        end
        checks++;
        if ({rd_valid_a, full_a, afull_a, ov_a, un_a} !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=00000",
                     {rd_valid_a, full_a, afull_a, ov_a, un_a});
        end
        checks++;
        if (empty_a !== 1'b1 || count_a !== 3'd0) begin
            failures++;
            $display("FAIL reset_empty got=%b/%0d exp=1/0", empty_a, count_a);
        end
        checks++;
        if (obs_b !== pack_b(eb)) begin
            failures++;
            $display("FAIL reset_b got=%h exp=%h", obs_b, pack_b(eb));
        end
        @(negedge clk);
        reset_n = 1;
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < 6; i++) begin
            step(1, byte_t'(8'h11 + i), 0);
            checks++;
            if (count_a !== 3'(i + 1) || afull_a !== (i >= 3) ||
                full_a !== (i == 5)) begin
                failures++;
                $display("FAIL fill_%0d got=cnt%0d af%b f%b exp=cnt%0d af%b f%b",
                         i, count_a, afull_a, full_a, i + 1, i >= 3, i == 5);
            end
        end
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 1);
            checks++;
            if (rd_valid_a !== 1'b1 || rd_data_a !== byte_t'(8'h11 + i)) begin
                failures++;
                $display("FAIL drain_%0d got=v%b %h exp=v1 %h",
                         i, rd_valid_a, rd_data_a, 8'h11 + i);
            end
        end
        step(0, 0, 0);
        checks++;
        if (rd_valid_a !== 1'b0 || empty_a !== 1'b1 || count_a !== 3'd0) begin
            failures++;
            $display("FAIL drain_end got=v%b e%b c%0d exp=v0 e1 c0",
                     rd_valid_a, empty_a, count_a);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 6; i++) step(1, byte_t'($urandom_range(0, 8'hA9)), 0);
        step(1, 8'hAA, 0);
        checks++;
        if (ov_a !== 1'b1 || count_a !== 3'd6 || full_a !== 1'b1) begin
            failures++;
            $display("FAIL overflow_pulse got=ov%b c%0d f%b exp=ov1 c6 f1",
                     ov_a, count_a, full_a);
        end
        step(0, 0, 0);
        checks++;
        if (ov_a !== 1'b0 || count_a !== 3'd6) begin
            failures++;
            $display("FAIL overflow_clear got=ov%b c%0d exp=ov0 c6", ov_a, count_a);
        end
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 1);
            checks++;
            if (rd_data_a === 8'hAA || obs_a !== pack_a(ea)) begin
                failures++;
                $display("FAIL overflow_drain_%0d got=%h exp=%h",
                         i, obs_a, pack_a(ea));
            end
        end
    endtask

    task automatic test_underflow();
        step(1, 8'h55, 1);
        checks++;
        if (un_a !== 1'b1 || rd_valid_a !== 1'b0 || count_a !== 3'd1) begin
            failures++;
            $display("FAIL underflow_pulse got=u%b v%b c%0d exp=u1 v0 c1",
                     un_a, rd_valid_a, count_a);
        end
        step(0, 0, 1);
        checks++;
        if (un_a !== 1'b0 || rd_valid_a !== 1'b1 || rd_data_a !== 8'h55) begin
            failures++;
            $display("FAIL underflow_next got=u%b v%b %h exp=u0 v1 55",
                     un_a, rd_valid_a, rd_data_a);
        end
    endtask

    task automatic test_full_rw();
        byte_t words[6];
        for (int i = 0; i < 6; i++) begin
            words[i] = byte_t'($urandom_range(0, 8'h76));
            step(1, words[i], 0);
        end
        step(1, 8'h77, 1);
        checks++;
        if (count_a !== 3'd6 || full_a !== 1'b1 || ov_a !== 1'b0 ||
            rd_valid_a !== 1'b1 || rd_data_a !== words[0]) begin
            failures++;
            $display("FAIL full_rw got=c%0d f%b ov%b v%b %h exp=c6 f1 ov0 v1 %h",
                     count_a, full_a, ov_a, rd_valid_a, rd_data_a, words[0]);
        end
        for (int i = 1; i < 6; i++) begin
            step(0, 0, 1);
            checks++;
            if (rd_data_a !== words[i]) begin
                failures++;
                $display("FAIL full_rw_rd%0d got=%h exp=%h", i, rd_data_a, words[i]);
            end
        end
        step(0, 0, 1);
        checks++;
        if (rd_data_a !== 8'h77 || empty_a !== 1'b1) begin
            failures++;
            $display("FAIL full_rw_last got=%h e%b exp=77 e1", rd_data_a, empty_a);
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 20; i++) begin
            step(1, byte_t'(i), 0, 1, byte_t'(i), 0);
            step(0, 0, 1, 0, 0, 1);
            checks++;
            if (rd_data_a !== byte_t'(i) || rd_data_b !== byte_t'(i) ||
                rd_valid_a !== 1'b1 || rd_valid_b !== 1'b1) begin
                failures++;
                $display("FAIL wrap_%0d got=a%h b%h exp=%h",
                         i, rd_data_a, rd_data_b, i);
            end
        end
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 0, 1, byte_t'($urandom), 0);
            checks++;
            if (afull_b !== (i == 7) || full_b !== (i == 7) ||
                count_b !== 4'(i + 1)) begin
                failures++;
                $display("FAIL b_fill_%0d got=af%b f%b c%0d exp=af%b f%b c%0d",
                         i, afull_b, full_b, count_b, i == 7, i == 7, i + 1);
            end
        end
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 0, 0, 0, 1);
            checks++;
            if (obs_b !== pack_b(eb)) begin
                failures++;
                $display("FAIL b_drain_%0d got=%h exp=%h", i, obs_b, pack_b(eb));
            end
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) step(1, byte_t'($urandom), 0);
        step(0, 0, 1);
        checks++;
        if (rd_valid_a !== 1'b1 || count_a !== 3'd2) begin
            failures++;
            $display("FAIL areset_pre got=v%b c%0d exp=v1 c2", rd_valid_a, count_a);
        end
        #2;
        reset_n = 0;
        #1;
        checks++;
        if (rd_valid_a !== 1'b0 || count_a !== 3'd0 || empty_a !== 1'b1 ||
            rd_data_a !== 8'h00 || full_a !== 1'b0) begin
            failures++;
            $display("FAIL areset_now got=v%b c%0d e%b %h exp=v0 c0 e1 00",
                     rd_valid_a, count_a, empty_a, rd_data_a);
        end
        qa.delete(); qb.delete();
        ea = reset_exp(); eb = reset_exp();
        @(negedge clk);
        reset_n = 1;
        step(0, 0, 1);
        checks++;
        if (un_a !== 1'b1 || rd_valid_a !== 1'b0 || empty_a !== 1'b1 ||
            count_a !== 3'd0) begin
            failures++;
            $display("FAIL areset_after got=u%b v%b e%b c%0d exp=u1 v0 e1 c0",
                     un_a, rd_valid_a, empty_a, count_a);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            int bias;
            bias = (n < 200) ? 70 : 30;
            step($urandom_range(0, 99) < bias, byte_t'($urandom),
                 $urandom_range(0, 99) < 100 - bias,
                 $urandom_range(0, 99) < bias, byte_t'($urandom),
                 $urandom_range(0, 99) < 100 - bias);
            checks++;
            if (obs_a !== pack_a(ea)) begin
                failures++;
                $display("FAIL rand_a_%0d got=%h exp=%h", n, obs_a, pack_a(ea));
            end
            checks++;
            if (obs_b !== pack_b(eb)) begin
                failures++;
                $display("FAIL rand_b_%0d got=%h exp=%h", n, obs_b, pack_b(eb));
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_overflow();
        test_underflow();
        test_full_rw();
        test_wrap();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
